alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single combinational `alu` between `NREQ` requesters (requester 0 = EX-stage pipeline, requester 1+ = auxiliary units such as address generation or a debug port). It accepts one operation at a time through a valid/ready handshake, drives the ALU operand/function inputs from registered copies, and captures `result`/`Z`/`N` into an output register. It then returns them to the granting requester through a second valid/ready handshake. Arbitration is round-robin, so no requester starves.

## Interface
Parameters:
- `NREQ`, 2: number of requesters, 2..8.
- `IDXW`, `$clog2(NREQ)`: grant index width (derived, not overridden).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester operation request.
- `req_ready`  out  NREQ  one-hot accept strobe.
- `req_opa`, `req_opb`, `req_imm`  in  NREQ×32  per-requester operand A, register operand B, extended immediate.
- `req_func`  in  NREQ×3  per-requester `alu_func_t`.
- `req_bsrc`  in  NREQ  1 selects `req_imm` as operand B.
- `rsp_valid`  out  NREQ  one-hot response valid.
- `rsp_ready`  in  NREQ  per-requester response accept.
- `rsp_result`  out  32  shared registered result.
- `rsp_z`, `rsp_n`  out  1  shared registered zero / negative flags.
- `busy`  out  1  high whenever state ≠ IDLE.
- `grant_idx`  out  IDXW  index of current owner, valid while `busy`.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `req_valid`, the `rr_arbiter` selects the first set bit searching from `last+1` upward with wrap.
  - `req_ready[sel]`=1 combinationally in that cycle; the handshake completes when valid && ready.
  - On handshake: latch opa/opb/imm/func/bsrc and `sel`, set `last`←`sel`, go to EXEC.
  - No valid request: stay in IDLE, all `req_ready`=0.
- EXEC:
  - Latched operands drive the ALU instance.
  - At the clock edge, capture `result`, `Z`, `N` into `rsp_*` registers and go to RESP.
  - `req_ready` is all-zero.
- RESP:
  - `rsp_valid[grant]`=1; `rsp_*` hold stable.
  - On `rsp_ready[grant]`: clear `rsp_valid`, go to IDLE.
  - `rsp_ready` from non-granted requesters is ignored.
- Arithmetic is exactly the ALU semantics:
  - ADD / SUB wrap mod 2^32.
  - SLT is unsigned compare.
  - SLL/SRL use operand B[5:0]; shift amounts of 32..63 yield 0.
- `req_*` inputs are sampled only at handshake. Later changes from the requester do not affect an in-flight operation.
- A requester deasserting `req_valid` before being granted is legal and simply loses its turn.

## Timing
- Reset (`rst_n`=0 at edge):
  - state←IDLE, `last`←NREQ-1 so requester 0 wins first.
  - `rsp_valid`=0, `rsp_result`=0, `rsp_z`=0, `rsp_n`=0, `busy`=0, `grant_idx`=0, `req_ready`=0.
- Reset takes priority over every transition. Reset asserted in EXEC or RESP aborts the operation with no response ever issued.
- Latency: handshake in cycle T → `rsp_valid` high in cycle T+2.
- Minimum issue interval is 3 cycles. With `rsp_ready` tied high, the next accept happens in T+3.
- `rsp_ready` low holds RESP indefinitely with outputs unchanged. No timeout.
- Simultaneous requests: exactly one grant per IDLE cycle. With all requesters continuously valid, they are served in strict rotation 0,1,…,NREQ-1,0.
- `req_ready` depends combinationally on `req_valid`. `rsp_valid` is registered only.

## Structure
- `alu_pkg` holds:
  - `alu_func_t` enum: ADD=000, SUB=001, AND=010, OR=011, XOR=100, SLT=101, SLL=110, SRL=111.
  - `arb_state_t` enum {IDLE, EXEC, RESP}.
- Sub-module `rr_arbiter`:
  - Combinational.
  - Inputs: `req` vector and `last` pointer.
  - Outputs: one-hot `gnt`, `gnt_idx`, `any`.
- The `alu` is instantiated inside, with `OpBSrcE` driven by the latched bsrc.

## Test plan
- Reset, then req0 ADD opa=5 opb=7 bsrc=0, `rsp_ready`=1:
  - `req_ready[0]` same cycle.
  - `rsp_valid[0]` 2 cycles later; result=12, Z=0, N=0.
- req0 and req1 valid together (req0 SUB 3−3, req1 XOR 0xFFFF0000^0x0000FFFF):
  - req0 served first with result=0, Z=1.
  - req1 then returns 0xFFFFFFFF, N=1.
  - A third back-to-back pair grants req0 again.
- req1 SLL opa=1, bsrc=1, imm=31 → result=0x80000000, N=1. Same op with imm=40 → result=0, Z=1.
- Hold `rsp_ready[0]`=0 for 4 cycles after an SLT 2<9:
  - `rsp_valid[0]` and result=1 stay stable throughout.
  - `req_ready` stays 0 despite req1 valid.
  - Release → IDLE, then req1 is accepted the next cycle.
- Change `req_opa[0]` after its handshake → response reflects the originally latched value.
- Assert `rst_n`=0 during EXEC → all outputs zero next cycle, no `rsp_valid`, and requester 0 has priority afterwards.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU function encoding and arbiter FSM state types
package alu_pkg;
  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011,
    XOR = 3'b100,
    SLT = 3'b101,
    SLL = 3'b110,
    SRL = 3'b111
  } alu_func_t;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;
endpackage

// File: rtl/alu.sv
// alu: combinational 32-bit ALU; a/b/imm/func/OpBSrcE in, result plus zero (Z) and negative (N) flags out
module alu
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] imm,
  input  alu_func_t   func,
  input  logic        OpBSrcE,
  output logic [31:0] result,
  output logic        Z,
  output logic        N
);
  logic [31:0] op_b;
  always_comb begin
    op_b = OpBSrcE ? imm : b;
    result = '0;
    unique case (func)
      ADD: result = a + op_b;
      SUB: result = a - op_b;
      AND: result = a & op_b;
      OR:  result = a | op_b;
      XOR: result = a ^ op_b;
      SLT: result = {31'd0, a < op_b};
      SLL: result = op_b[5] ? '0 : a << op_b[4:0];
      SRL: result = op_b[5] ? '0 : a >> op_b[4:0];
      default: result = '0;
    endcase
  end
  assign Z = result == '0;
  assign N = result[31];
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; req/last in, one-hot gnt, gnt_idx and any out
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            any
);
  logic [IDXW-1:0] idx;
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    any = 1'b0;
    idx = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = IDXW'((int'(last) + i) % NREQ);
      if (req[idx]) begin
        gnt = NREQ'(1) << idx;
        gnt_idx = idx;
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one ALU; req_* valid/ready in, rsp_* valid/ready out, busy and grant_idx status
module alu_arbiter
  import alu_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int IDXW = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0][31:0] req_opa,
  input  logic [NREQ-1:0][31:0] req_opb,
  input  logic [NREQ-1:0][31:0] req_imm,
  input  logic [NREQ-1:0][2:0]  req_func,
  input  logic [NREQ-1:0]       req_bsrc,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [31:0]           rsp_result,
  output logic                  rsp_z,
  output logic                  rsp_n,
  output logic                  busy,
  output logic [IDXW-1:0]       grant_idx
);
  arb_state_t      state_q, state_d;
  logic [NREQ-1:0] gnt;
  logic [IDXW-1:0] sel, last_q, gnt_q;
  logic            any, take;
  logic [31:0]     opa_q, opb_q, imm_q, alu_res;
  alu_func_t       func_q;
  logic            bsrc_q, alu_z, alu_n;
  rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_arb (
    .req(req_valid), .last(last_q), .gnt(gnt), .gnt_idx(sel), .any(any)
  );
  alu u_alu (
    .a(opa_q), .b(opb_q), .imm(imm_q), .func(func_q), .OpBSrcE(bsrc_q),
    .result(alu_res), .Z(alu_z), .N(alu_n)
  );
  assign take = state_q == IDLE && any;
  always_ff @(posedge clk) state_q <= !rst_n ? IDLE : state_d;
  always_comb
    state_d = state_q == IDLE ? (any ? EXEC : IDLE) :
              state_q == EXEC ? RESP :
              rsp_ready[gnt_q] ? IDLE : RESP;
  // req_ready is masked during reset so no handshake appears to complete while rst_n is low
  always_comb begin
    req_ready = (state_q == IDLE && rst_n) ? gnt : '0;
    rsp_valid = state_q == RESP ? NREQ'(1) << gnt_q : '0;
    busy = state_q != IDLE;
    grant_idx = gnt_q;
  end
  // last_q and gnt_q track the same owner but reset differently: last points at NREQ-1 so requester 0 wins first
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= IDXW'(NREQ - 1);
      gnt_q <= '0;
      rsp_result <= '0;
      rsp_z <= 1'b0;
      rsp_n <= 1'b0;
    end else begin
      if (take) begin
        last_q <= sel;
        gnt_q <= sel;
      end
      if (state_q == EXEC) begin
        rsp_result <= alu_res;
        rsp_z <= alu_z;
        rsp_n <= alu_n;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (take) begin
      opa_q <= req_opa[sel];
      opb_q <= req_opb[sel];
      imm_q <= req_imm[sel];
      func_q <= alu_func_t'(req_func[sel]);
      bsrc_q <= req_bsrc[sel];
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized self-checking bench for alu_arbiter against a behavioural model
module tb_alu_arbiter;
  localparam int NREQ = 3;
  localparam int IDXW = $clog2(NREQ);
  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][31:0] req_opa = '0;
  logic [NREQ-1:0][31:0] req_opb = '0;
  logic [NREQ-1:0][31:0] req_imm = '0;
  logic [NREQ-1:0][2:0]  req_func = '0;
  logic [NREQ-1:0]       req_bsrc = '0;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready = '1;
  logic [31:0]           rsp_result;
  logic                  rsp_z, rsp_n, busy;
  logic [IDXW-1:0]       grant_idx;
  int vectors = 0;
  int miscompares = 0;
  int exp_last = NREQ - 1;
  alu_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_opa(req_opa), .req_opb(req_opb), .req_imm(req_imm), .req_func(req_func),
    .req_bsrc(req_bsrc), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_z(rsp_z), .rsp_n(rsp_n), .busy(busy), .grant_idx(grant_idx)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] ref_alu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int s;
    s = int'(b % 64);
    case (f)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (a < b) ? 32'd1 : 32'd0;
      3'd6: return s < 32 ? a << s : 32'd0;
      default: return s < 32 ? a >> s : 32'd0;
    endcase
  endfunction
  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction
  function automatic logic [31:0] model_result(input int g);
    return ref_alu(req_func[g], req_opa[g], req_bsrc[g] ? req_imm[g] : req_opb[g]);
  endfunction
  task automatic set_req(input int r, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic bs);
    req_func[r] = f; req_opa[r] = a; req_opb[r] = b; req_imm[r] = imm; req_bsrc[r] = bs;
  endtask
  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; rsp_ready = '1;
    @(posedge clk); #1;
    rst_n = 1'b1; exp_last = NREQ - 1;
  endtask
  // Starts in an IDLE cycle with inputs set; ends in the IDLE cycle three clocks later.
  // After the handshake the granted requester's fields are scrambled so latching is exercised.
  task automatic observe_txn(input int g, input bit drop, output logic [NREQ-1:0] rdy, output logic [NREQ-1:0] rv1,
                             output logic [NREQ-1:0] rv2, output logic [31:0] res, output logic z, output logic n);
    #1 rdy = req_ready;
    @(posedge clk); #1;
    rv1 = rsp_valid;
    if (drop) req_valid[g] = 1'b0;
    req_opa[g] = $urandom; req_opb[g] = $urandom; req_imm[g] = $urandom;
    @(posedge clk); #1;
    rv2 = rsp_valid; res = rsp_result; z = rsp_z; n = rsp_n;
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0; req_valid = '1; rsp_ready = '1;
    @(posedge clk); #1;
    vectors++; if (req_ready !== '0) begin miscompares++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    vectors++; if (rsp_valid !== '0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    vectors++; if (rsp_result !== 32'd0) begin miscompares++; $display("FAIL reset_result: got %h want 0", rsp_result); end
    vectors++; if ({rsp_z, rsp_n, busy} !== 3'b000) begin miscompares++; $display("FAIL reset_flags_busy: got %b want 000", {rsp_z, rsp_n, busy}); end
    vectors++; if (grant_idx !== '0) begin miscompares++; $display("FAIL reset_grant_idx: got %0d want 0", grant_idx); end
    req_valid = '0; rst_n = 1'b1; exp_last = NREQ - 1;
  endtask
  task automatic test_add();
    logic [NREQ-1:0] rdy, rv1, rv2, oh;
    logic [31:0] res, exp;
    logic z, n;
    int g;
    set_req(0, 3'd0, 32'd5, 32'd7, 32'd0, 1'b0);
    req_valid = 3'b001;
    g = rr_pick(req_valid, exp_last); exp = model_result(g); oh = NREQ'(1) << g; exp_last = g;
    observe_txn(g, 1'b1, rdy, rv1, rv2, res, z, n);
    vectors++; if (rdy !== oh) begin miscompares++; $display("FAIL add_ready: got %b want %b", rdy, oh); end
    vectors++; if (rv1 !== '0) begin miscompares++; $display("FAIL add_rsp_early: got %b want 0", rv1); end
    vectors++; if (rv2 !== oh) begin miscompares++; $display("FAIL add_rsp_valid: got %b want %b", rv2, oh); end
    vectors++; if (res !== exp) begin miscompares++; $display("FAIL add_result: got %h want %h", res, exp); end
    vectors++; if ({z, n} !== {exp == 0, exp[31]}) begin miscompares++; $display("FAIL add_flags: got %b want %b", {z, n}, {exp == 0, exp[31]}); end
  endtask
  task automatic test_back_to_back();
    logic [NREQ-1:0] rdy, rv1, rv2, oh;
    logic [31:0] res, exp;
    logic z, n;
    int g;
    do_reset();
    set_req(0, 3'd1, 32'd3, 32'd3, 32'd0, 1'b0);
    set_req(1, 3'd4, 32'hFFFF0000, 32'h0000FFFF, 32'd0, 1'b0);
    req_valid = 3'b011;
    for (int t = 0; t < 3; t++) begin
      g = rr_pick(req_valid, exp_last); exp = model_result(g); oh = NREQ'(1) << g; exp_last = g;
      observe_txn(g, 1'b0, rdy, rv1, rv2, res, z, n);
      vectors++; if (rdy !== oh) begin miscompares++; $display("FAIL b2b_ready[%0d]: got %b want %b", t, rdy, oh); end
      vectors++; if (rv2 !== oh) begin miscompares++; $display("FAIL b2b_rsp_valid[%0d]: got %b want %b", t, rv2, oh); end
      vectors++; if (res !== exp) begin miscompares++; $display("FAIL b2b_result[%0d]: got %h want %h", t, res, exp); end
      vectors++; if ({z, n} !== {exp == 0, exp[31]}) begin miscompares++; $display("FAIL b2b_flags[%0d]: got %b want %b", t, {z, n}, {exp == 0, exp[31]}); end
    end
    req_valid = '0;
  endtask
  task automatic test_shift();
    logic [NREQ-1:0] rdy, rv1, rv2, oh;
    logic [31:0] res, exp;
    logic z, n;
    int g;
    logic [31:0] amts [2] = '{32'd31, 32'd40};
    for (int t = 0; t < 2; t++) begin
      set_req(1, 3'd6, 32'd1, 32'd0, amts[t], 1'b1);
      req_valid = 3'b010;
      g = rr_pick(req_valid, exp_last); exp = model_result(g); oh = NREQ'(1) << g; exp_last = g;
      observe_txn(g, 1'b1, rdy, rv1, rv2, res, z, n);
      vectors++; if (rdy !== oh) begin miscompares++; $display("FAIL sll_ready[%0d]: got %b want %b", t, rdy, oh); end
      vectors++; if (res !== exp) begin miscompares++; $display("FAIL sll_result[%0d]: got %h want %h", t, res, exp); end
      vectors++; if ({z, n} !== {exp == 0, exp[31]}) begin miscompares++; $display("FAIL sll_flags[%0d]: got %b want %b", t, {z, n}, {exp == 0, exp[31]}); end
    end
  endtask
  task automatic test_hold();
    logic [NREQ-1:0] rdy, rv1, rv2, oh;
    logic [31:0] res, exp;
    logic z, n;
    int g;
    set_req(0, 3'd5, 32'd2, 32'd9, 32'd0, 1'b0);
    req_valid = 3'b001; rsp_ready = 3'b110;
    g = rr_pick(req_valid, exp_last); exp = model_result(g); oh = NREQ'(1) << g; exp_last = g;
    #1;
    vectors++; if (req_ready !== oh) begin miscompares++; $display("FAIL hold_ready: got %b want %b", req_ready, oh); end
    @(posedge clk); #1;
    req_valid = 3'b010;
    set_req(1, 3'd3, $urandom, $urandom, 32'd0, 1'b0);
    @(posedge clk); #1;
    for (int t = 0; t < 4; t++) begin
      vectors++; if (rsp_valid !== oh) begin miscompares++; $display("FAIL hold_rsp_valid[%0d]: got %b want %b", t, rsp_valid, oh); end
      vectors++; if (rsp_result !== exp) begin miscompares++; $display("FAIL hold_result[%0d]: got %h want %h", t, rsp_result, exp); end
      vectors++; if (req_ready !== '0) begin miscompares++; $display("FAIL hold_no_accept[%0d]: got %b want 0", t, req_ready); end
      @(posedge clk); #1;
    end
    rsp_ready = '1;
    @(posedge clk); #1;
    g = rr_pick(req_valid, exp_last); exp = model_result(g); oh = NREQ'(1) << g; exp_last = g;
    observe_txn(g, 1'b1, rdy, rv1, rv2, res, z, n);
    vectors++; if (rdy !== oh) begin miscompares++; $display("FAIL hold_next_ready: got %b want %b", rdy, oh); end
    vectors++; if (res !== exp) begin miscompares++; $display("FAIL hold_next_result: got %h want %h", res, exp); end
  endtask
  task automatic test_latch();
    logic [NREQ-1:0] rdy, rv1, rv2, oh;
    logic [31:0] res, exp;
    logic z, n;
    int g;
    set_req(0, 3'd0, 32'd100, 32'd1, 32'd0, 1'b0);
    req_valid = 3'b001;
    g = rr_pick(req_valid, exp_last); exp = model_result(g); oh = NREQ'(1) << g; exp_last = g;
    observe_txn(g, 1'b1, rdy, rv1, rv2, res, z, n);
    vectors++; if (res !== exp) begin miscompares++; $display("FAIL latch_result: got %h want %h", res, exp); end
  endtask
  task automatic test_reset_exec();
    logic [NREQ-1:0] rdy, rv1, rv2, oh;
    logic [31:0] res, exp;
    logic z, n;
    int g;
    set_req(1, 3'd3, 32'h0000_F000, 32'h8000_0001, 32'd0, 1'b0);
    req_valid = 3'b010;
    @(posedge clk); #1;
    rst_n = 1'b0; req_valid = '0;
    @(posedge clk); #1;
    vectors++; if (rsp_valid !== '0) begin miscompares++; $display("FAIL rexec_rsp_valid: got %b want 0", rsp_valid); end
    vectors++; if (rsp_result !== 32'd0) begin miscompares++; $display("FAIL rexec_result: got %h want 0", rsp_result); end
    vectors++; if ({rsp_z, rsp_n, busy} !== 3'b000) begin miscompares++; $display("FAIL rexec_flags_busy: got %b want 000", {rsp_z, rsp_n, busy}); end
    vectors++; if (grant_idx !== '0 || req_ready !== '0) begin miscompares++; $display("FAIL rexec_grant_ready: got %0d/%b want 0/0", grant_idx, req_ready); end
    rst_n = 1'b1; exp_last = NREQ - 1;
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      vectors++; if (rsp_valid !== '0) begin miscompares++; $display("FAIL rexec_no_rsp[%0d]: got %b want 0", t, rsp_valid); end
    end
    set_req(0, 3'd2, $urandom, $urandom, 32'd0, 1'b0);
    set_req(1, 3'd4, $urandom, $urandom, 32'd0, 1'b0);
    req_valid = 3'b011;
    g = rr_pick(req_valid, exp_last); exp = model_result(g); oh = NREQ'(1) << g; exp_last = g;
    observe_txn(g, 1'b1, rdy, rv1, rv2, res, z, n);
    vectors++; if (rdy !== oh) begin miscompares++; $display("FAIL rexec_prio: got %b want %b", rdy, oh); end
    vectors++; if (res !== exp) begin miscompares++; $display("FAIL rexec_result_after: got %h want %h", res, exp); end
    req_valid = '0;
  endtask
  task automatic test_random();
    logic [NREQ-1:0] rdy, rv1, rv2, oh;
    logic [31:0] res, exp;
    logic z, n;
    int g;
    for (int t = 0; t < 80; t++) begin
      for (int r = 0; r < NREQ; r++)
        set_req(r, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom_range(0, 1) ? $urandom_range(0, 63) : $urandom, 1'($urandom_range(0, 1)));
      req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      if (req_valid == '0) begin
        #1;
        vectors++; if (req_ready !== '0 || busy !== 1'b0) begin miscompares++; $display("FAIL rand_idle[%0d]: got %b/%b want 0/0", t, req_ready, busy); end
        @(posedge clk); #1;
      end else begin
        g = rr_pick(req_valid, exp_last); exp = model_result(g); oh = NREQ'(1) << g; exp_last = g;
        observe_txn(g, 1'($urandom_range(0, 1)), rdy, rv1, rv2, res, z, n);
        vectors++; if (rdy !== oh) begin miscompares++; $display("FAIL rand_ready[%0d]: got %b want %b", t, rdy, oh); end
        vectors++; if (rv1 !== '0 || rv2 !== oh) begin miscompares++; $display("FAIL rand_rsp_valid[%0d]: got %b,%b want 0,%b", t, rv1, rv2, oh); end
        vectors++; if (res !== exp) begin miscompares++; $display("FAIL rand_result[%0d]: got %h want %h", t, res, exp); end
        vectors++; if ({z, n} !== {exp == 0, exp[31]}) begin miscompares++; $display("FAIL rand_flags[%0d]: got %b want %b", t, {z, n}, {exp == 0, exp[31]}); end
      end
    end
    req_valid = '0;
  endtask
  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_shift();
    test_hold();
    test_latch();
    test_reset_exec();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
